// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter: pipeline writeback wins, long-latency results queue and drain into idle slots.
// Optional macro WB_ARB_PENDING_CHK_EN adds the chk_addr/chk_pending pending-register lookup.
module wb_port_arbiter #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pipe_write_en,
  input  logic [ADDR_W-1:0] pipe_write_addr,
  input  logic [DATA_W-1:0] pipe_write_data,
  input  logic              lu_valid,
  output logic              lu_ready,
  input  logic [ADDR_W-1:0] lu_addr,
  input  logic [DATA_W-1:0] lu_data,
  output logic              rf_write_en,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic              stall_req,
`ifdef WB_ARB_PENDING_CHK_EN
  input  logic [ADDR_W-1:0] chk_addr,
  output logic              chk_pending,
`endif
  output logic              err_collision
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [3:0]       MAX_C   = 4'(MAX_WAIT);

  logic [ADDR_W-1:0] r_mem_addr [DEPTH];
  logic [DATA_W-1:0] r_mem_data [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [3:0]        r_wait_cnt;
  logic              r_lu_ready;
  logic              r_stall_req;
  logic              r_err_collision;
  logic              r_rf_write_en_p1;
  logic [ADDR_W-1:0] r_rf_write_addr_p1;
  logic [DATA_W-1:0] r_rf_write_data_p1;

  logic              w_fifo_ne;
  logic              w_accept;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count_next;
  logic [3:0]        w_wait_next;

  // Stage p0: grant decision; the pipeline always wins when it writes, so a pop only fills idle slots.
  assign w_fifo_ne = (r_count != '0);
  assign w_accept  = lu_valid && r_lu_ready;
  assign w_push    = w_accept && (lu_addr != '0);
  assign w_pop     = w_fifo_ne && !pipe_write_en;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 1'b1;
      2'b01:   w_count_next = r_count - 1'b1;
      default: w_count_next = r_count;
    endcase
  end

  always_comb begin
    w_wait_next = r_wait_cnt;
    if (w_pop || !w_fifo_ne)
      w_wait_next = '0;
    else if (r_wait_cnt != MAX_C)
      w_wait_next = r_wait_cnt + 1'b1;
  end

  // FIFO storage carries no reset; validity is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_addr[r_wr_ptr] <= lu_addr;
      r_mem_data[r_wr_ptr] <= lu_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr        <= '0;
      r_rd_ptr        <= '0;
      r_count         <= '0;
      r_wait_cnt      <= '0;
      r_lu_ready      <= 1'b0;
      r_stall_req     <= 1'b0;
      r_err_collision <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count     <= w_count_next;
      r_wait_cnt  <= w_wait_next;
      r_lu_ready  <= (w_count_next < DEPTH_C);
      r_stall_req <= (w_wait_next == MAX_C);
      if (pipe_write_en && r_stall_req) r_err_collision <= 1'b1;
    end
  end

  // Stage p1: registered regfile write port; address/data hold when idle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rf_write_en_p1   <= 1'b0;
      r_rf_write_addr_p1 <= '0;
      r_rf_write_data_p1 <= '0;
    end else if (pipe_write_en) begin
      r_rf_write_en_p1   <= 1'b1;
      r_rf_write_addr_p1 <= pipe_write_addr;
      r_rf_write_data_p1 <= pipe_write_data;
    end else if (w_pop) begin
      r_rf_write_en_p1   <= 1'b1;
      r_rf_write_addr_p1 <= r_mem_addr[r_rd_ptr];
      r_rf_write_data_p1 <= r_mem_data[r_rd_ptr];
    end else begin
      r_rf_write_en_p1   <= 1'b0;
    end
  end

  assign lu_ready      = r_lu_ready;
  assign stall_req     = r_stall_req;
  assign err_collision = r_err_collision;
  assign rf_write_en   = r_rf_write_en_p1;
  assign rf_write_addr = r_rf_write_addr_p1;
  assign rf_write_data = r_rf_write_data_p1;

`ifdef WB_ARB_PENDING_CHK_EN
  logic [DEPTH-1:0] r_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
    end else begin
      if (w_push) r_valid[r_wr_ptr] <= 1'b1;
      if (w_pop)  r_valid[r_rd_ptr] <= 1'b0;
    end
  end

  // Address 0 is never stored, so the chk_addr!=0 qualifier only matters for the live handshake.
  always_comb begin
    chk_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_valid[i] && (r_mem_addr[i] == chk_addr)) chk_pending = 1'b1;
    end
    if (w_accept && (lu_addr == chk_addr)) chk_pending = 1'b1;
    if (chk_addr == '0) chk_pending = 1'b0;
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter with default parameters (DEPTH=2, MAX_WAIT=4).
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_write_en;
  logic [4:0]  pipe_write_addr;
  logic [31:0] pipe_write_data;
  logic        lu_valid;
  logic        lu_ready;
  logic [4:0]  lu_addr;
  logic [31:0] lu_data;
  logic        rf_write_en;
  logic [4:0]  rf_write_addr;
  logic [31:0] rf_write_data;
  logic        stall_req;
  logic        err_collision;
`ifdef WB_ARB_PENDING_CHK_EN
  logic [4:0]  chk_addr;
  logic        chk_pending;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_arbiter dut (
    .clk             (clk),
    .rst             (rst),
    .pipe_write_en   (pipe_write_en),
    .pipe_write_addr (pipe_write_addr),
    .pipe_write_data (pipe_write_data),
    .lu_valid        (lu_valid),
    .lu_ready        (lu_ready),
    .lu_addr         (lu_addr),
    .lu_data         (lu_data),
    .rf_write_en     (rf_write_en),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .stall_req       (stall_req),
`ifdef WB_ARB_PENDING_CHK_EN
    .chk_addr        (chk_addr),
    .chk_pending     (chk_pending),
`endif
    .err_collision   (err_collision)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_pipe(input logic en, input logic [4:0] a, input logic [31:0] d);
    pipe_write_en   = en;
    pipe_write_addr = a;
    pipe_write_data = d;
  endtask

  task automatic drive_lu(input logic v, input logic [4:0] a, input logic [31:0] d);
    lu_valid = v;
    lu_addr  = a;
    lu_data  = d;
  endtask

  initial begin
    rst = 1'b0;
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
`ifdef WB_ARB_PENDING_CHK_EN
    chk_addr = 5'd0;
`endif
    tick();
    tick();
    check("rst_rf_en",    rf_write_en,   0);
    check("rst_rf_addr",  rf_write_addr, 0);
    check("rst_rf_data",  rf_write_data, 0);
    check("rst_stall",    stall_req,     0);
    check("rst_err",      err_collision, 0);
    check("rst_lu_ready", lu_ready,      0);
    rst = 1'b1;
    tick();
    check("post_rst_lu_ready", lu_ready, 1);

    // Minimum latency: lu presented in this cycle, captured next edge, written the edge after.
    drive_lu(1'b1, 5'd3, 32'hDEADBEEF);
    tick();
    check("lat_n1_en", rf_write_en, 0);
    drive_lu(1'b0, 5'd0, 32'd0);
    tick();
    check("lat_n2_en",   rf_write_en,   1);
    check("lat_n2_addr", rf_write_addr, 3);
    check("lat_n2_data", rf_write_data, 32'hDEADBEEF);
    tick();
    check("lat_idle_en",   rf_write_en,   0);
    check("lat_idle_addr", rf_write_addr, 3);

    // Pipe and lu both active: pipe wins every slot, FIFO fills after two accepts.
    for (int k = 0; k < 4; k++) begin
      drive_pipe(1'b1, 5'(10 + k), 32'(32'h1000 + k));
      drive_lu(1'b1, 5'(20 + k), 32'(32'hA0 + k));
      tick();
      check($sformatf("both_en_%0d", k),    rf_write_en,   1);
      check($sformatf("both_addr_%0d", k),  rf_write_addr, 10 + k);
      check($sformatf("both_data_%0d", k),  rf_write_data, 32'h1000 + k);
      check($sformatf("both_ready_%0d", k), lu_ready,      (k == 0) ? 1 : 0);
      check($sformatf("both_stall_%0d", k), stall_req,     0);
    end
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    tick();
    check("drain0_addr",  rf_write_addr, 20);
    check("drain0_data",  rf_write_data, 32'hA0);
    check("drain0_ready", lu_ready,      1);
    tick();
    check("drain1_addr", rf_write_addr, 21);
    check("drain1_data", rf_write_data, 32'hA1);
    tick();
    check("drain_idle_en", rf_write_en, 0);

    // Starvation: one queued entry, pipe busy four cycles -> bubble request.
    drive_pipe(1'b1, 5'd1, 32'h100);
    drive_lu(1'b1, 5'd7, 32'h77);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive_pipe(1'b1, 5'(1 + i), 32'(32'h100 + i));
      tick();
      check($sformatf("starve_stall_%0d", i), stall_req, (i == 4) ? 1 : 0);
    end
    drive_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("forced_pop_en",   rf_write_en,   1);
    check("forced_pop_addr", rf_write_addr, 7);
    check("forced_pop_data", rf_write_data, 32'h77);
    check("forced_pop_stall", stall_req,    0);
    check("forced_pop_err",  err_collision, 0);

    // Contract violation: pipe write during stall_req still lands, error latches.
    drive_pipe(1'b1, 5'd1, 32'h200);
    drive_lu(1'b1, 5'd9, 32'h99);
    tick();
    drive_lu(1'b0, 5'd0, 32'd0);
    for (int i = 1; i <= 4; i++) begin
      drive_pipe(1'b1, 5'(1 + i), 32'(32'h200 + i));
      tick();
    end
    check("coll_stall_up", stall_req, 1);
    drive_pipe(1'b1, 5'd12, 32'hC0C0);
    tick();
    check("coll_addr",  rf_write_addr, 12);
    check("coll_data",  rf_write_data, 32'hC0C0);
    check("coll_err",   err_collision, 1);
    check("coll_stall", stall_req,     1);
    drive_pipe(1'b0, 5'd0, 32'd0);
    tick();
    check("coll_pop_addr", rf_write_addr, 9);
    check("coll_pop_data", rf_write_data, 32'h99);
    check("coll_pop_stall", stall_req,    0);
    tick();
    check("coll_err_sticky", err_collision, 1);

    // Reset with two entries queued discards them.
    drive_pipe(1'b1, 5'd1, 32'h1);
    drive_lu(1'b1, 5'd13, 32'h13);
    tick();
    drive_lu(1'b1, 5'd14, 32'h14);
    tick();
    check("mid_full_ready", lu_ready, 0);
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
    rst = 1'b0;
    #1;
    check("mid_rst_ready", lu_ready,      0);
    check("mid_rst_en",    rf_write_en,   0);
    check("mid_rst_data",  rf_write_data, 0);
    check("mid_rst_err",   err_collision, 0);
    tick();
    rst = 1'b1;
    tick();
    check("after_rst_ready", lu_ready,    1);
    check("after_rst_en",    rf_write_en, 0);
    check("after_rst_stall", stall_req,   0);
    tick();
    check("after_rst_en2", rf_write_en, 0);

    // Address-0 long-latency entry is accepted but never stored.
    drive_lu(1'b1, 5'd0, 32'h12345678);
    tick();
    check("zero_ready", lu_ready,      1);
    check("zero_en",    rf_write_en,   0);
    check("zero_data",  rf_write_data, 0);
    drive_pipe(1'b1, 5'd2, 32'h22);
    drive_lu(1'b1, 5'd3, 32'h33);
    tick();
    check("zero_pipe_addr", rf_write_addr, 2);
    check("zero_cnt_ready", lu_ready,      1);
    drive_pipe(1'b0, 5'd0, 32'd0);
    drive_lu(1'b0, 5'd0, 32'd0);
`ifdef WB_ARB_PENDING_CHK_EN
    chk_addr = 5'd3;
    #1;
    check("chk_r3", chk_pending, 1);
    chk_addr = 5'd0;
    #1;
    check("chk_r0", chk_pending, 0);
`endif
    tick();
    check("zero_pop_addr", rf_write_addr, 3);
    check("zero_pop_data", rf_write_data, 32'h33);
    tick();
    check("zero_final_en",   rf_write_en,   0);
    check("zero_final_data", rf_write_data, 32'h33);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
Shares the single register-file write port between the in-order pipeline writeback (MEM/WB stage output) and one long-latency producer (divider / AXI load return).
- Pipeline writes have default priority.
- Long-latency results queue in a small FIFO and drain into idle write slots.
- A starvation counter asks the pipeline controller for a bubble so queued results cannot wait indefinitely.
- Sits between MEM/WB and the regfile write port.

Parameters:
DATA_W, 32, register data width
ADDR_W, 5, register address width
DEPTH, 2, long-latency FIFO entries (power of two, >=2)
MAX_WAIT, 4, consecutive pipeline wins with FIFO non-empty before a bubble is requested (1..15)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
pipe_write_en  in  1  pipeline writeback valid, no backpressure
pipe_write_addr  in  ADDR_W  pipeline destination register
pipe_write_data  in  DATA_W  pipeline result
lu_valid  in  1  long-latency result valid
lu_ready  out  1  FIFO can accept
lu_addr  in  ADDR_W  long-latency destination register
lu_data  in  DATA_W  long-latency result
rf_write_en  out  1  regfile write enable
rf_write_addr  out  ADDR_W  regfile write address
rf_write_data  out  DATA_W  regfile write data
stall_req  out  1  request one pipeline writeback bubble
err_collision  out  1  sticky: pipe_write_en seen while stall_req=1

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO emptied; wait_cnt=0.
  - rf_write_en=0, rf_write_addr=0, rf_write_data=0.
  - stall_req=0, err_collision=0, lu_ready=0 while rst=0.
  - Any in-flight queued results are discarded.
- lu_ready = registered "FIFO not full", i.e. count<DEPTH at the start of the cycle.
  - A push never uses a slot freed by a same-cycle pop.
- Accept: lu_valid && lu_ready.
  - Entries with lu_addr==0 are accepted and dropped (not stored).
  - All other entries are pushed with addr and data.
- Grant, evaluated each cycle, result registered onto rf_* at the next edge (1-cycle latency):
  - stall_req==1 and FIFO non-empty: pop head -> rf_*. If pipe_write_en is also 1, the pipeline write still wins (no data loss) and err_collision sets.
  - else pipe_write_en==1: pipe_* -> rf_*.
  - else FIFO non-empty: pop head -> rf_*.
  - else rf_write_en=0; rf_write_addr and rf_write_data hold their previous values.
- Minimum long-latency latency is 2 cycles: accept at edge N, earliest rf_write_en at edge N+2. There is no FIFO bypass.
- Starvation counter wait_cnt:
  - Increments on each cycle the pipeline wins while the FIFO is non-empty.
  - Clears on any pop or when the FIFO is empty.
  - Saturates at MAX_WAIT.
- stall_req is registered: 1 in the cycle after wait_cnt reaches MAX_WAIT.
  - Drops in the cycle after the forced pop (wait_cnt cleared).
  - Contract: the pipeline controller keeps pipe_write_en=0 in any cycle with stall_req=1.
- Pipeline writes to addr 0 pass through unchanged; the regfile ignores them.
- Ordering: FIFO is strictly in order. No WAW checking between pipe and FIFO entries; issue logic guarantees it.
- Simultaneous push and pop on a non-full FIFO: both occur and count is unchanged.
- Pointers wrap modulo DEPTH.

Optional Feature:
Macro WB_ARB_PENDING_CHK_EN.
- Defined: adds input chk_addr[ADDR_W] and output chk_pending[1].
  - chk_pending is combinational: 1 iff chk_addr!=0 and chk_addr matches any valid FIFO entry, or matches lu_addr on an accepting lu handshake this cycle.
  - Used by the hazard unit to stall reads of pending registers.
- Undefined: ports absent, no comparators.

Test Plan:
- rst=0 mid-queue (2 entries held) -> FIFO emptied, next cycle rf_write_en=0, stall_req=0, lu_ready=1 after rst=1.
- Pipe idle; lu push addr 3 data 0xDEADBEEF at edge N -> rf_write_en=1, addr 3, data 0xDEADBEEF at edge N+2.
- Pipe and lu both active every cycle, DEPTH=2 -> lu_ready=0 after 2 accepts; no rf write of lu data until pipe idles; pipe writes all land in order.
- Queued entry with pipe_write_en=1 continuously, MAX_WAIT=4 -> stall_req=1 after 4 pipe wins; with pipe then 0, head popped next edge; stall_req=0 the cycle after.
- Violate contract: pipe_write_en=1 while stall_req=1 -> pipe data written, err_collision=1 and stays 1 until reset.
- lu push with addr 0, data 0x12345678 -> accepted (lu_ready stays 1), FIFO count unchanged, no rf write with that data. With WB_ARB_PENDING_CHK_EN, chk_addr=3 with a queued entry for r3 -> chk_pending=1; chk_addr=0 -> chk_pending=0.
